demux_1x2_16: RTL and testbench

- Registered 1-to-2 demultiplexer for 16-bit words: the inverse of the team's 16-bit 2x1 mux.
- One input stream, steered per word by a select bit, drives two independent output channels.
- Each output channel has its own small FIFO with valid/ready handshaking, so a stalled consumer on one side never corrupts data on the other.
- Sits after the datapath mux stage, fanning one shared 16-bit bus back out to two consumers.

---
 rtl/demux_1x2_16.sv | 105 ++++++++++
 tb/tb_demux_1x2_16.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_16.sv
// Registered 1-to-2 demultiplexer: one 16-bit input stream steered by in_sel
// into two independent show-ahead FIFOs, each with its own valid/ready port.

module demux_1x2_16_ch #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 2,
  localparam int LW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [LW-1:0]    o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_pop;

  assign o_valid = (r_level != '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_level = r_level;
  assign w_pop   = o_valid && i_ready;
  // Head is gated so an empty channel presents zero rather than stale storage.
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

module demux_1x2_16 #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 2,
  localparam int LW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [LW-1:0]    out0_level,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [LW-1:0]    out1_level
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0]            w_push, w_full, w_valid, w_ready;
  logic [NUM_CH-1:0][WIDTH-1:0] w_data;
  logic [NUM_CH-1:0][LW-1:0]    w_level;

  // Only registered state feeds in_ready, so consumers never loop back to the source.
  assign in_ready = !w_full[in_sel];
  assign w_ready  = {out1_ready, out0_ready};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_push[k] = in_valid && in_ready && (in_sel == 1'(k));
    demux_1x2_16_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[k]),
      .i_data  (in_data),
      .i_ready (w_ready[k]),
      .o_full  (w_full[k]),
      .o_valid (w_valid[k]),
      .o_data  (w_data[k]),
      .o_level (w_level[k])
    );
  end

  assign out0_data  = w_data[0];
  assign out0_valid = w_valid[0];
  assign out0_level = w_level[0];
  assign out1_data  = w_data[1];
  assign out1_valid = w_valid[1];
  assign out1_level = w_level[1];
endmodule

// File: tb/tb_demux_1x2_16.sv
// Bench for demux_1x2_16: directed scenario tasks plus a per-channel scoreboard.
module tb_demux_1x2_16;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sel = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             out0_valid, out1_valid;
  logic             out0_ready = 1'b0, out1_ready = 1'b0;
  logic [LW-1:0]    out0_level, out1_level;

  int checks = 0;
  int failures = 0;
  int pops0 = 0;
  logic [WIDTH-1:0] q0[$], q1[$];
  logic [WIDTH-1:0] mon_exp;

  demux_1x2_16 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_level(out0_level),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_level(out1_level)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; this snapshot is what the next rising edge acts on.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out0_valid && out0_ready) begin
        checks++;
        pops0++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL sb_ch0 got=%0d expected nothing (queue empty)", out0_data);
        end else begin
          mon_exp = q0.pop_front();
          if (out0_data !== mon_exp) begin
            failures++;
            $display("FAIL sb_ch0 got=%0d exp=%0d", out0_data, mon_exp);
          end
        end
      end
      if (out1_valid && out1_ready) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL sb_ch1 got=%0d expected nothing (queue empty)", out1_data);
        end else begin
          mon_exp = q1.pop_front();
          if (out1_data !== mon_exp) begin
            failures++;
            $display("FAIL sb_ch1 got=%0d exp=%0d", out1_data, mon_exp);
          end
        end
      end
      if (!out0_valid || !out1_valid) begin
        checks++;
        if ((!out0_valid && out0_data !== '0) || (!out1_valid && out1_data !== '0)) begin
          failures++;
          $display("FAIL idle_data_zero got0=%0d got1=%0d exp=0", out0_data, out1_data);
        end
      end
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
  end

  task test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b%b exp=00", out1_valid, out0_valid);
    end
    checks++;
    if (out0_level !== '0 || out1_level !== '0) begin
      failures++; $display("FAIL reset_level got=%0d/%0d exp=0/0", out0_level, out1_level);
    end
    checks++;
    if (out0_data !== '0 || out1_data !== '0) begin
      failures++; $display("FAIL reset_data got=%0d/%0d exp=0/0", out0_data, out1_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task test_basic_routing();
    out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    in_sel = 1'b0; in_data = 16'd15163; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 16'd15163) begin
      failures++; $display("FAIL route_ch0 got v=%b d=%0d exp v=1 d=15163", out0_valid, out0_data);
    end
    in_sel = 1'b1; in_data = 16'd12512;
    @(negedge clk);
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b1 || out1_data !== 16'd12512) begin
      failures++;
      $display("FAIL route_ch1 got v0=%b v1=%b d1=%0d exp v0=0 v1=1 d1=12512", out0_valid, out1_valid, out1_data);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out1_valid !== 1'b0 || out0_level !== '0 || out1_level !== '0) begin
      failures++;
      $display("FAIL route_drain got v1=%b l0=%0d l1=%0d exp 0 0 0", out1_valid, out0_level, out1_level);
    end
    out0_ready = 1'b0; out1_ready = 1'b0;
  endtask

  task test_fill_backpressure();
    @(negedge clk);
    in_sel = 1'b0; in_data = 16'd235; in_valid = 1'b1;
    @(negedge clk);
    in_data = 16'd275;
    @(negedge clk);
    checks++;
    if (out0_level !== LW'(2) || out0_data !== 16'd235) begin
      failures++; $display("FAIL fill_level got l=%0d d=%0d exp l=2 d=235", out0_level, out0_data);
    end
    in_data = 16'd823;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (out0_level !== LW'(2) || out0_data !== 16'd235) begin
      failures++; $display("FAIL fill_held got l=%0d d=%0d exp l=2 d=235", out0_level, out0_data);
    end
    out0_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out0_level !== LW'(1) || out0_data !== 16'd275) begin
      failures++; $display("FAIL fill_pop got l=%0d d=%0d exp l=1 d=275", out0_level, out0_data);
    end
    out0_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL fill_reopen got=%b exp=1", in_ready);
    end
    @(negedge clk);
    checks++;
    if (out0_level !== LW'(2) || out0_data !== 16'd275) begin
      failures++; $display("FAIL fill_accept got l=%0d d=%0d exp l=2 d=275", out0_level, out0_data);
    end
    in_valid = 1'b0;
  endtask

  task test_channel_isolation();
    in_sel = 1'b1; in_data = 16'd7224; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL iso_in_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 16'd7224 || out1_level !== LW'(1)) begin
      failures++;
      $display("FAIL iso_ch1 got v=%b d=%0d l=%0d exp v=1 d=7224 l=1", out1_valid, out1_data, out1_level);
    end
    checks++;
    if (out0_level !== LW'(2) || out0_data !== 16'd275) begin
      failures++; $display("FAIL iso_ch0 got l=%0d d=%0d exp l=2 d=275", out0_level, out0_data);
    end
    out1_ready = 1'b1;
    @(negedge clk);
    out1_ready = 1'b0;
    checks++;
    if (out1_level !== '0) begin
      failures++; $display("FAIL iso_drain got l=%0d exp l=0", out1_level);
    end
  endtask

  task test_push_pop();
    in_sel = 1'b1; in_data = 16'd3865; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (out1_level !== LW'(1) || out1_data !== 16'd3865) begin
      failures++; $display("FAIL pp_setup got l=%0d d=%0d exp l=1 d=3865", out1_level, out1_data);
    end
    in_data = 16'd3965; out1_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out1_ready = 1'b0;
    checks++;
    if (out1_level !== LW'(1) || out1_data !== 16'd3965) begin
      failures++; $display("FAIL pp_same_edge got l=%0d d=%0d exp l=1 d=3965", out1_level, out1_data);
    end
    out1_ready = 1'b1;
    @(negedge clk);
    out1_ready = 1'b0;
    out0_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out0_ready = 1'b0;
    checks++;
    if (out0_level !== '0 || out1_level !== '0) begin
      failures++; $display("FAIL pp_drain got l0=%0d l1=%0d exp 0/0", out0_level, out1_level);
    end
  endtask

  task test_wrap();
    logic [WIDTH-1:0] words [6];
    int  idx, cyc, start;
    bit  acc;
    words[0] = 16'd2548; words[1] = 16'd2854; words[2] = 16'd4658;
    words[3] = 16'd3956; words[4] = 16'd30;   words[5] = 16'd2485;
    idx = 0; cyc = 0; acc = 1'b0; start = pops0;
    while ((idx < 6 || out0_valid) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (acc) idx++;
      out0_ready = !out0_ready;
      if (idx < 6) begin
        in_sel = 1'b0; in_data = words[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
    end
    in_valid = 1'b0; out0_ready = 1'b0;
    checks++;
    if (cyc >= 200) begin
      failures++; $display("FAIL wrap_timeout got cycles=%0d exp <200", cyc);
    end
    checks++;
    if (pops0 - start != 6 || q0.size() != 0) begin
      failures++; $display("FAIL wrap_count got pops=%0d left=%0d exp pops=6 left=0", pops0 - start, q0.size());
    end
  endtask

  task test_async_reset();
    @(negedge clk);
    in_sel = 1'b0; in_data = 16'd11; in_valid = 1'b1;
    @(negedge clk); in_data = 16'd12;
    @(negedge clk); in_sel = 1'b1; in_data = 16'd21;
    @(negedge clk); in_data = 16'd22;
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (out0_level !== LW'(2) || out1_level !== LW'(2)) begin
      failures++; $display("FAIL arst_setup got l0=%0d l1=%0d exp 2/2", out0_level, out1_level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_level !== '0 || out1_level !== '0) begin
      failures++;
      $display("FAIL arst_immediate got v=%b%b l0=%0d l1=%0d exp all 0", out1_valid, out0_valid, out0_level, out1_level);
    end
    q0.delete(); q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    in_sel = 1'b0; in_data = 16'd8254; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 16'd8254 || out0_level !== LW'(1)) begin
      failures++;
      $display("FAIL arst_after_ch0 got v=%b d=%0d l=%0d exp v=1 d=8254 l=1", out0_valid, out0_data, out0_level);
    end
    checks++;
    if (out1_valid !== 1'b0 || out1_level !== '0) begin
      failures++; $display("FAIL arst_after_ch1 got v=%b l=%0d exp v=0 l=0", out1_valid, out1_level);
    end
    out0_ready = 1'b1;
    @(negedge clk);
    out0_ready = 1'b0;
    checks++;
    if (out0_level !== '0) begin
      failures++; $display("FAIL arst_drain got l=%0d exp 0", out0_level);
    end
  endtask

  initial begin
    test_reset();
    test_basic_routing();
    test_fill_backpressure();
    test_channel_isolation();
    test_push_pop();
    test_wrap();
    test_async_reset();
    @(negedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++; $display("FAIL sb_leftover got q0=%0d q1=%0d exp 0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
